// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the master controller state type.
// Imported by both the master and the slave controllers.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HBURST_INCR = 3'b001;

  localparam logic [31:0] WORD_STRIDE = 32'd4;

  typedef enum logic [2:0] {
    MST_IDLE,
    MST_ADDR,
    MST_BURST,
    MST_LAST,
    MST_ERR
  } mstState_e;

  // An INCR burst may not carry SEQ across a 1 KB page, so such beats restart with NSEQ.
  function automatic logic onKbBoundary(input logic [31:0] addr);
    return (addr[9:0] == 10'd0);
  endfunction

endpackage

// File: rtl/ahb_beat_counter.sv
// Address and remaining-beat tracker for the AHB master; advances once per
// accepted address phase and flags the final beat and 1 KB page starts.
module ahb_beat_counter
  import ahb_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        load_i,
  input  logic [31:0] loadAddr_i,
  input  logic [3:0]  loadLen_i,
  input  logic        advance_i,
  output logic [31:0] addr_o,
  output logic        lastBeat_o,
  output logic        boundary_o
);

  logic [31:0] addr_q, addr_d;
  logic [3:0]  beatsLeft_q, beatsLeft_d;

  always_comb begin
    addr_d      = addr_q;
    beatsLeft_d = beatsLeft_q;
    if (load_i) begin
      addr_d      = loadAddr_i;
      beatsLeft_d = loadLen_i;
    end else if (advance_i) begin
      addr_d = addr_q + WORD_STRIDE;
      if (beatsLeft_q != 4'd0) begin
        beatsLeft_d = beatsLeft_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_q      <= 32'd0;
      beatsLeft_q <= 4'd0;
    end else begin
      addr_q      <= addr_d;
      beatsLeft_q <= beatsLeft_d;
    end
  end

  // A zero count means the beat currently on the bus is the final one.
  assign addr_o     = addr_q;
  assign lastBeat_o = (beatsLeft_q == 4'd0);
  assign boundary_o = onKbBoundary(addr_q);

endmodule

// File: rtl/ahb_master_cntrlr.sv
// AHB-Lite INCR burst master: turns one request into a pipelined burst of word
// transfers, streaming write data in and read data out, with error abort.
module ahb_master_cntrlr
  import ahb_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_len,
  input  logic [31:0] wdata,
  output logic        wdata_pop,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        done,
  output logic        error,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  mstState_e   state_q, state_d;
  logic        write_q, write_d;
  logic        accept;
  logic        advance;
  logic        beatOk;
  logic        dataPhase;
  logic        lastBeat;
  logic        boundary;
  logic [31:0] beatAddr;

  assign accept    = req_valid && (state_q == MST_IDLE);
  assign dataPhase = (state_q == MST_BURST) || (state_q == MST_LAST);

  ahb_beat_counter u_beatCounter (
    .clk        (clk),
    .n_rst      (n_rst),
    .load_i     (accept),
    .loadAddr_i (req_addr),
    .loadLen_i  (req_len),
    .advance_i  (advance),
    .addr_o     (beatAddr),
    .lastBeat_o (lastBeat),
    .boundary_o (boundary)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= MST_IDLE;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
    end
  end

  // Address phase of beat n rides alongside the data phase of beat n-1, so a
  // single hready both accepts the address and completes the previous data.
  always_comb begin
    state_d = state_q;
    write_d = accept ? req_write : write_q;
    htrans  = HTRANS_IDLE;
    advance = 1'b0;
    beatOk  = 1'b0;
    done    = 1'b0;
    error   = 1'b0;
    case (state_q)
      MST_IDLE: begin
        if (req_valid) begin
          state_d = MST_ADDR;
        end
      end
      MST_ADDR: begin
        htrans = HTRANS_NSEQ;
        if (hready) begin
          advance = 1'b1;
          state_d = lastBeat ? MST_LAST : MST_BURST;
        end
      end
      MST_BURST: begin
        htrans = boundary ? HTRANS_NSEQ : HTRANS_SEQ;
        if (hresp) begin
          if (hready) begin
            error   = 1'b1;
            state_d = MST_IDLE;
          end else begin
            state_d = MST_ERR;
          end
        end else if (hready) begin
          beatOk  = 1'b1;
          advance = 1'b1;
          state_d = lastBeat ? MST_LAST : MST_BURST;
        end
      end
      MST_LAST: begin
        if (hresp) begin
          if (hready) begin
            error   = 1'b1;
            state_d = MST_IDLE;
          end else begin
            state_d = MST_ERR;
          end
        end else if (hready) begin
          beatOk  = 1'b1;
          done    = 1'b1;
          state_d = MST_IDLE;
        end
      end
      MST_ERR: begin
        if (hready) begin
          error   = 1'b1;
          state_d = MST_IDLE;
        end
      end
      default: begin
        state_d = MST_IDLE;
      end
    endcase
  end

  assign req_ready   = (state_q == MST_IDLE);
  assign haddr       = beatAddr;
  assign hwrite      = write_q;
  assign hsize       = HSIZE_WORD;
  assign hburst      = HBURST_INCR;
  assign hwdata      = (dataPhase && write_q) ? wdata : 32'd0;
  assign wdata_pop   = beatOk && write_q;
  assign rdata_valid = beatOk && !write_q;
  assign rdata       = rdata_valid ? hrdata : 32'd0;

endmodule

// File: tb/tb_ahb_master_cntrlr.sv
// Directed self-checking bench for the AHB-Lite burst master controller.
module tb_ahb_master_cntrlr;

  logic        clk;
  logic        n_rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic [31:0] wdata;
  logic        wdata_pop;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        error;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  int compareCount  = 0;
  int mismatchCount = 0;
  int popCount      = 0;
  int rvalidCount   = 0;
  int doneCount     = 0;
  int errCount      = 0;

  ahb_master_cntrlr dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .wdata       (wdata),
    .wdata_pop   (wdata_pop),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done),
    .error       (error),
    .haddr       (haddr),
    .htrans      (htrans),
    .hwrite      (hwrite),
    .hsize       (hsize),
    .hburst      (hburst),
    .hwdata      (hwdata),
    .hrdata      (hrdata),
    .hready      (hready),
    .hresp       (hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies are taken mid-cycle, when combinational outputs are settled.
  always @(negedge clk) begin
    if (wdata_pop === 1'b1) popCount++;
    if (rdata_valid === 1'b1) rvalidCount++;
    if (done === 1'b1) doneCount++;
    if (error === 1'b1) errCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic stepTo();
    @(posedge clk);
    #1;
  endtask

  task automatic clearCounts();
    popCount    = 0;
    rvalidCount = 0;
    doneCount   = 0;
    errCount    = 0;
  endtask

  // Issues one request from IDLE; returns one step later with the DUT in ADDR.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [3:0] l);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_len   = l;
    @(negedge clk);
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    stepTo();
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    n_rst     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_len   = 4'd0;
    wdata     = 32'hDEADBEEF;
    hrdata    = 32'hCAFEF00D;
    hready    = 1'b1;
    hresp     = 1'b0;

    #12;
    checkOutput("rst_htrans", 32'(htrans), 32'h0);
    checkOutput("rst_haddr", haddr, 32'h0);
    checkOutput("rst_hwrite", 32'(hwrite), 32'h0);
    checkOutput("rst_hwdata", hwdata, 32'h0);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_pop", 32'(wdata_pop), 32'h0);
    checkOutput("rst_rvalid", 32'(rdata_valid), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_error", 32'(error), 32'h0);
    checkOutput("rst_hsize", 32'(hsize), 32'h2);
    checkOutput("rst_hburst", 32'(hburst), 32'h1);
    stepTo();
    n_rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    stepTo();

    $display("[TB] single write @0x100");
    clearCounts();
    applyStimulus(1'b1, 32'h100, 4'd0);
    wdata = 32'hA5A50001;
    @(negedge clk);
    checkOutput("w1_htrans", 32'(htrans), 32'h2);
    checkOutput("w1_haddr", haddr, 32'h100);
    checkOutput("w1_hwrite", 32'(hwrite), 32'h1);
    checkOutput("w1_pop_addr", 32'(wdata_pop), 32'h0);
    checkOutput("w1_req_ready_busy", 32'(req_ready), 32'h0);
    stepTo();
    @(negedge clk);
    checkOutput("w1_htrans_last", 32'(htrans), 32'h0);
    checkOutput("w1_pop", 32'(wdata_pop), 32'h1);
    checkOutput("w1_hwdata", hwdata, 32'hA5A50001);
    checkOutput("w1_done", 32'(done), 32'h1);
    stepTo();
    @(negedge clk);
    checkOutput("w1_idle_ready", 32'(req_ready), 32'h1);
    checkOutput("w1_idle_done", 32'(done), 32'h0);
    stepTo();
    checkOutput("w1_pop_count", 32'(popCount), 32'd1);
    checkOutput("w1_done_count", 32'(doneCount), 32'd1);

    $display("[TB] 4-beat read @0x200");
    clearCounts();
    applyStimulus(1'b0, 32'h200, 4'd3);
    @(negedge clk);
    checkOutput("r4_htrans0", 32'(htrans), 32'h2);
    checkOutput("r4_haddr0", haddr, 32'h200);
    checkOutput("r4_hwrite", 32'(hwrite), 32'h0);
    checkOutput("r4_rvalid0", 32'(rdata_valid), 32'h0);
    for (int i = 1; i < 4; i++) begin
      stepTo();
      rd = 32'h11110000 + 32'(i);
      hrdata = rd;
      @(negedge clk);
      checkOutput("r4_htrans_seq", 32'(htrans), 32'h3);
      checkOutput("r4_haddr", haddr, 32'h200 + 32'(4 * i));
      checkOutput("r4_rvalid", 32'(rdata_valid), 32'h1);
      checkOutput("r4_rdata", rdata, rd);
      checkOutput("r4_done_early", 32'(done), 32'h0);
    end
    stepTo();
    hrdata = 32'h11110004;
    @(negedge clk);
    checkOutput("r4_htrans_last", 32'(htrans), 32'h0);
    checkOutput("r4_rdata_last", rdata, 32'h11110004);
    checkOutput("r4_done", 32'(done), 32'h1);
    stepTo();
    checkOutput("r4_rvalid_count", 32'(rvalidCount), 32'd4);
    checkOutput("r4_done_count", 32'(doneCount), 32'd1);

    $display("[TB] 4-beat write with wait states");
    clearCounts();
    applyStimulus(1'b1, 32'h40, 4'd3);
    wdata = 32'h00000A00;
    @(negedge clk);
    checkOutput("ws_haddr0", haddr, 32'h40);
    stepTo();
    @(negedge clk);
    checkOutput("ws_haddr1", haddr, 32'h44);
    checkOutput("ws_pop0", 32'(wdata_pop), 32'h1);
    checkOutput("ws_hwdata0", hwdata, 32'h00000A00);
    stepTo();
    wdata  = 32'h00000A01;
    hready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      checkOutput("ws_stall_haddr", haddr, 32'h48);
      checkOutput("ws_stall_htrans", 32'(htrans), 32'h3);
      checkOutput("ws_stall_hwdata", hwdata, 32'h00000A01);
      checkOutput("ws_stall_pop", 32'(wdata_pop), 32'h0);
      stepTo();
    end
    hready = 1'b1;
    @(negedge clk);
    checkOutput("ws_pop1", 32'(wdata_pop), 32'h1);
    stepTo();
    wdata = 32'h00000A02;
    @(negedge clk);
    checkOutput("ws_haddr3", haddr, 32'h4C);
    checkOutput("ws_hwdata2", hwdata, 32'h00000A02);
    stepTo();
    wdata = 32'h00000A03;
    @(negedge clk);
    checkOutput("ws_htrans_last", 32'(htrans), 32'h0);
    checkOutput("ws_hwdata3", hwdata, 32'h00000A03);
    checkOutput("ws_done", 32'(done), 32'h1);
    stepTo();
    checkOutput("ws_pop_count", 32'(popCount), 32'd4);
    checkOutput("ws_done_count", 32'(doneCount), 32'd1);

    $display("[TB] 3-beat read across 1 KB page");
    clearCounts();
    applyStimulus(1'b0, 32'h3FC, 4'd2);
    @(negedge clk);
    checkOutput("kb_htrans0", 32'(htrans), 32'h2);
    checkOutput("kb_haddr0", haddr, 32'h3FC);
    stepTo();
    @(negedge clk);
    checkOutput("kb_htrans1", 32'(htrans), 32'h2);
    checkOutput("kb_haddr1", haddr, 32'h400);
    stepTo();
    @(negedge clk);
    checkOutput("kb_htrans2", 32'(htrans), 32'h3);
    checkOutput("kb_haddr2", haddr, 32'h404);
    stepTo();
    @(negedge clk);
    checkOutput("kb_done", 32'(done), 32'h1);
    stepTo();
    checkOutput("kb_rvalid_count", 32'(rvalidCount), 32'd3);

    $display("[TB] 2-beat read wrapping the address space");
    clearCounts();
    applyStimulus(1'b0, 32'hFFFFFFFC, 4'd1);
    @(negedge clk);
    checkOutput("wrap_haddr0", haddr, 32'hFFFFFFFC);
    stepTo();
    @(negedge clk);
    checkOutput("wrap_haddr1", haddr, 32'h0);
    checkOutput("wrap_htrans1", 32'(htrans), 32'h2);
    stepTo();
    @(negedge clk);
    checkOutput("wrap_done", 32'(done), 32'h1);
    stepTo();

    $display("[TB] 8-beat write with two-cycle error on beat 3");
    clearCounts();
    applyStimulus(1'b1, 32'h800, 4'd7);
    @(negedge clk);
    checkOutput("er_haddr0", haddr, 32'h800);
    stepTo();
    @(negedge clk);
    checkOutput("er_haddr1", haddr, 32'h804);
    stepTo();
    @(negedge clk);
    checkOutput("er_haddr2", haddr, 32'h808);
    stepTo();
    hresp  = 1'b1;
    hready = 1'b0;
    @(negedge clk);
    checkOutput("er_first_haddr", haddr, 32'h80C);
    checkOutput("er_first_pop", 32'(wdata_pop), 32'h0);
    checkOutput("er_first_error", 32'(error), 32'h0);
    stepTo();
    hready = 1'b1;
    @(negedge clk);
    checkOutput("er_second_htrans", 32'(htrans), 32'h0);
    checkOutput("er_second_error", 32'(error), 32'h1);
    checkOutput("er_second_pop", 32'(wdata_pop), 32'h0);
    checkOutput("er_second_done", 32'(done), 32'h0);
    stepTo();
    hresp = 1'b0;
    @(negedge clk);
    checkOutput("er_idle_ready", 32'(req_ready), 32'h1);
    checkOutput("er_idle_htrans", 32'(htrans), 32'h0);
    stepTo();
    checkOutput("er_pop_count", 32'(popCount), 32'd2);
    checkOutput("er_err_count", 32'(errCount), 32'd1);
    checkOutput("er_done_count", 32'(doneCount), 32'd0);

    $display("[TB] single read with one-cycle error");
    clearCounts();
    applyStimulus(1'b0, 32'h10, 4'd0);
    stepTo();
    hresp  = 1'b1;
    hready = 1'b1;
    @(negedge clk);
    checkOutput("e1_error", 32'(error), 32'h1);
    checkOutput("e1_rvalid", 32'(rdata_valid), 32'h0);
    checkOutput("e1_done", 32'(done), 32'h0);
    stepTo();
    hresp = 1'b0;
    @(negedge clk);
    checkOutput("e1_idle_ready", 32'(req_ready), 32'h1);
    checkOutput("e1_idle_error", 32'(error), 32'h0);
    stepTo();

    $display("[TB] reset during 4-beat write");
    clearCounts();
    applyStimulus(1'b1, 32'h80, 4'd3);
    stepTo();
    stepTo();
    n_rst = 1'b0;
    #1;
    checkOutput("mr_htrans", 32'(htrans), 32'h0);
    checkOutput("mr_haddr", haddr, 32'h0);
    checkOutput("mr_hwrite", 32'(hwrite), 32'h0);
    checkOutput("mr_hwdata", hwdata, 32'h0);
    checkOutput("mr_pop", 32'(wdata_pop), 32'h0);
    checkOutput("mr_done", 32'(done), 32'h0);
    checkOutput("mr_error", 32'(error), 32'h0);
    stepTo();
    n_rst = 1'b1;
    @(negedge clk);
    checkOutput("mr_req_ready", 32'(req_ready), 32'h1);
    checkOutput("mr_htrans_after", 32'(htrans), 32'h0);
    stepTo();
    checkOutput("mr_pop_count", 32'(popCount), 32'd1);
    checkOutput("mr_done_count", 32'(doneCount), 32'd0);
    checkOutput("mr_err_count", 32'(errCount), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
